// File: rtl/fetch_decode_unit_pkg.sv
// Shared definitions for the fetch/decode unit: instruction class codes,
// FSM state encoding and the ALU function type.
package fetch_decode_unit_pkg;

    localparam logic [3:0] CLS_ALUR  = 4'h0;
    localparam logic [3:0] CLS_ALUI  = 4'h8;
    localparam logic [3:0] CLS_CMPR  = 4'h2;
    localparam logic [3:0] CLS_CMPI  = 4'hA;
    localparam logic [3:0] CLS_BCOND = 4'h6;
    localparam logic [3:0] CLS_LD    = 4'h9;
    localparam logic [3:0] CLS_ST    = 4'h5;
    localparam logic [3:0] CLS_JAL   = 4'hB;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // {cmp, op[3:0]} as consumed by the ALU
    typedef logic [4:0] func_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fdu_decode.sv
// Combinational instruction decoder: maps a latched instruction word to ALU
// controls, register fields and class flags.
module fdu_decode
    import fetch_decode_unit_pkg::*;
(
    input  logic [31:0] iword,
    output func_t       func,
    output logic [31:0] imm,
    output logic [3:0]  rd,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic        alu_src_imm,
    output logic        is_alu,
    output logic        is_bcond,
    output logic        is_ld,
    output logic        is_st,
    output logic        is_jal,
    output logic        is_illegal
);

    assign imm = sext16(iword[23:8]);
    assign rd  = iword[31:28];
    assign rs1 = iword[27:24];
    assign rs2 = iword[23:20];

    always_comb begin
        func        = 5'b00000;
        alu_src_imm = 1'b0;
        is_alu      = 1'b0;
        is_bcond    = 1'b0;
        is_ld       = 1'b0;
        is_st       = 1'b0;
        is_jal      = 1'b0;
        is_illegal  = 1'b0;
        case (iword[3:0])
            CLS_ALUR: begin
                func   = {1'b0, iword[7:4]};
                is_alu = 1'b1;
            end
            CLS_ALUI: begin
                func        = {1'b0, iword[7:4]};
                alu_src_imm = 1'b1;
                is_alu      = 1'b1;
            end
            CLS_CMPR: begin
                func   = {1'b1, iword[7:4]};
                is_alu = 1'b1;
            end
            CLS_CMPI: begin
                func        = {1'b1, iword[7:4]};
                alu_src_imm = 1'b1;
                is_alu      = 1'b1;
            end
            CLS_BCOND: begin
                func     = {1'b1, iword[7:4]};
                is_bcond = 1'b1;
            end
            CLS_LD: begin
                alu_src_imm = 1'b1;
                is_ld       = 1'b1;
            end
            CLS_ST: begin
                alu_src_imm = 1'b1;
                is_st       = 1'b1;
            end
            CLS_JAL: begin
                alu_src_imm = 1'b1;
                is_jal      = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Multi-cycle fetch/decode sequencer: fetches a word, executes it in one
// cycle, optionally waits in MEM for a data access, and owns the PC.
//
// state | meaning
// FETCH | imem request outstanding at pc, waiting for imem_ack
// EXEC  | decoded controls valid, ALU/branch/JAL resolved, pc updated
// MEM   | load/store strobe held until dmem_done
// HALT  | illegal opcode seen, idle until reset
module fetch_decode_unit
    import fetch_decode_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output func_t       func,
    output logic [31:0] imm,
    output logic        alu_src_imm,
    output logic [3:0]  rd,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    input  logic        comp_true,
    input  logic [31:0] alu_result,
    input  logic        dmem_done,
    output logic [31:0] link_pc,
    output logic [31:0] pc,
    output logic        retire,
    output logic        illegal
);

    state_t      state;
    logic [31:0] iword;
    logic [31:0] pc_q;
    logic        illegal_q;

    logic is_alu, is_bcond, is_ld, is_st, is_jal, is_illegal;
    logic [31:0] pc_seq, br_target, jal_target;

    fdu_decode u_decode (
        .iword       (iword),
        .func        (func),
        .imm         (imm),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .alu_src_imm (alu_src_imm),
        .is_alu      (is_alu),
        .is_bcond    (is_bcond),
        .is_ld       (is_ld),
        .is_st       (is_st),
        .is_jal      (is_jal),
        .is_illegal  (is_illegal)
    );

    // Branch offset is in words; JAL targets are forced word-aligned.
    assign pc_seq     = pc_q + PC_STEP;
    assign br_target  = pc_seq + (imm << 2);
    assign jal_target = alu_result & ~32'h3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc_q      <= RESET_PC;
            iword     <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        iword <= imem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_illegal) begin
                        illegal_q <= 1'b1;
                        state     <= ST_HALT;
                    end else if (is_ld || is_st) begin
                        state <= ST_MEM;
                    end else begin
                        state <= ST_FETCH;
                        if (is_bcond)
                            pc_q <= comp_true ? br_target : pc_seq;
                        else if (is_jal)
                            pc_q <= jal_target;
                        else
                            pc_q <= pc_seq;
                    end
                end
                ST_MEM: begin
                    if (dmem_done) begin
                        pc_q  <= pc_seq;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Strobes are decoded from registered state; the MEM completion strobes
    // must follow dmem_done in the same cycle.
    always_comb begin
        imem_req = (state == ST_FETCH);
        reg_we   = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        retire   = 1'b0;
        case (state)
            ST_EXEC: begin
                reg_we = is_alu || is_jal;
                retire = is_alu || is_bcond || is_jal;
            end
            ST_MEM: begin
                mem_re = is_ld;
                mem_we = is_st;
                reg_we = is_ld && dmem_done;
                retire = dmem_done;
            end
            default: ;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign link_pc   = pc_seq;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench: directed scenarios with literal expectations followed by
// randomized traffic, all compared every cycle against an instruction-level model.
module tb_fetch_decode_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STEP   = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic [4:0]  func;
    logic [31:0] imm;
    logic        alu_src_imm;
    logic [3:0]  rd, rs1, rs2;
    logic        reg_we, mem_re, mem_we;
    logic        comp_true = 1'b0;
    logic [31:0] alu_result = 32'h0;
    logic        dmem_done = 1'b0;
    logic [31:0] link_pc, pc;
    logic        retire, illegal;

    always #5 clk = ~clk;

    fetch_decode_unit #(.RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .func(func), .imm(imm), .alu_src_imm(alu_src_imm),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .comp_true(comp_true), .alu_result(alu_result), .dmem_done(dmem_done),
        .link_pc(link_pc), .pc(pc), .retire(retire), .illegal(illegal)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: phase 0 waiting for instruction, 1 executing, 2 data access, 3 stopped.
    int          m_ph = 0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_iw = 32'h0;
    logic        m_ill = 1'b0;

    logic [3:0] legal_cls [8]   = '{4'h0, 4'h8, 4'h2, 4'hA, 4'h6, 4'h9, 4'h5, 4'hB};
    logic [3:0] illegal_cls [8] = '{4'h1, 4'h3, 4'h4, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};

    function automatic logic is_legal(input logic [3:0] c);
        return c inside {4'h0, 4'h8, 4'h2, 4'hA, 4'h6, 4'h9, 4'h5, 4'hB};
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] cls, input logic [3:0] fn,
                                       input logic [15:0] im, input logic [3:0] r_d,
                                       input logic [3:0] r_s1);
        return {r_d, r_s1, im, fn, cls};
    endfunction

    function automatic logic [151:0] expected();
        logic [3:0]  c;
        logic [4:0]  e_func;
        logic [31:0] e_imm;
        logic        e_src, e_we, e_re, e_mwe, e_ret;
        c      = m_iw[3:0];
        e_func = 5'd0;
        if (c == 4'h0 || c == 4'h8) e_func = {1'b0, m_iw[7:4]};
        if (c == 4'h2 || c == 4'hA || c == 4'h6) e_func = {1'b1, m_iw[7:4]};
        e_imm  = 32'($signed(m_iw[23:8]));
        e_src  = c inside {4'h8, 4'hA, 4'h9, 4'h5, 4'hB};
        e_we   = (m_ph == 1 && (c inside {4'h0, 4'h8, 4'h2, 4'hA, 4'hB}))
              || (m_ph == 2 && c == 4'h9 && dmem_done);
        e_re   = (m_ph == 2 && c == 4'h9);
        e_mwe  = (m_ph == 2 && c == 4'h5);
        e_ret  = (m_ph == 1 && is_legal(c) && c != 4'h9 && c != 4'h5)
              || (m_ph == 2 && dmem_done);
        return {m_ph == 0, m_pc, e_func, e_imm, e_src, m_iw[31:28], m_iw[27:24],
                m_iw[23:20], e_we, e_re, e_mwe, m_pc + STEP, m_pc, e_ret, m_ill};
    endfunction

    task automatic chk();
        logic [151:0] act, exp_v;
        act   = {imem_req, imem_addr, func, imm, alu_src_imm, rd, rs1, rs2,
                 reg_we, mem_re, mem_we, link_pc, pc, retire, illegal};
        exp_v = expected();
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act, exp_v);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic model_update();
        logic [3:0] c;
        c = m_iw[3:0];
        if (!rst_n) begin
            m_ph = 0; m_pc = RST_PC; m_iw = 32'h0; m_ill = 1'b0;
        end else if (m_ph == 0) begin
            if (imem_ack) begin m_iw = imem_rdata; m_ph = 1; end
        end else if (m_ph == 1) begin
            if (!is_legal(c)) begin
                m_ill = 1'b1; m_ph = 3;
            end else if (c == 4'h9 || c == 4'h5) begin
                m_ph = 2;
            end else begin
                m_ph = 0;
                if (c == 4'h6)
                    m_pc = m_pc + STEP + (comp_true ? 32'($signed(m_iw[23:8])) * 4 : 32'd0);
                else if (c == 4'hB)
                    m_pc = {alu_result[31:2], 2'b00};
                else
                    m_pc = m_pc + STEP;
            end
        end else if (m_ph == 2) begin
            if (dmem_done) begin m_pc = m_pc + STEP; m_ph = 0; end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        chk();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Drive a fetch acknowledged in the n-th request cycle; returns in EXEC.
    task automatic fetch(input logic [31:0] w, input int n);
        imem_ack = 1'b0;
        for (int i = 1; i < n; i++) begin settle(); tick(); end
        imem_ack = 1'b1; imem_rdata = w;
        settle(); tick();
        imem_ack = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] target);
        fetch(mk(4'hB, 4'h0, 16'h0, 4'h1, 4'h0), 1);
        alu_result = target;
        settle(); tick();
    endtask

    initial begin
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state, ALUI with 3-cycle fetch latency
        settle();
        lit("reset_pc", pc, 32'h0);
        lit("reset_illegal", {31'd0, illegal}, 32'd0);
        lit("reset_retire", {31'd0, retire}, 32'd0);
        tick();
        settle(); lit("addr_hold2", imem_addr, 32'h0); tick();
        imem_ack = 1'b1; imem_rdata = mk(4'h8, 4'h0, 16'h0005, 4'h3, 4'h1);
        settle(); lit("addr_hold3", imem_addr, 32'h0); tick();
        imem_ack = 1'b0;
        settle();
        lit("alui_func", {27'd0, func}, 32'd0);
        lit("alui_imm", imm, 32'd5);
        lit("alui_src", {31'd0, alu_src_imm}, 32'd1);
        lit("alui_we_ret", {30'd0, reg_we, retire}, 32'd3);
        tick();
        settle(); lit("alui_pc", pc, 32'h4); tick();

        // JAL at 0x20
        jump_to(32'h20);
        fetch(mk(4'hB, 4'h0, 16'h0, 4'h7, 4'h2), 1);
        alu_result = 32'h203;
        settle();
        lit("jal_link", link_pc, 32'h24);
        lit("jal_we", {31'd0, reg_we}, 32'd1);
        tick();
        settle(); lit("jal_pc", pc, 32'h200); tick();

        // BCOND at 0x100, imm = -2, taken and not taken
        jump_to(32'h100);
        fetch(mk(4'h6, 4'h3, 16'hFFFE, 4'h0, 4'h1), 2);
        comp_true = 1'b1;
        settle();
        lit("bcond_func", {27'd0, func}, 32'h13);
        lit("bcond_we_ret", {30'd0, reg_we, retire}, 32'd1);
        tick(); comp_true = 1'b0;
        settle(); lit("bcond_taken_pc", pc, 32'h0FC); tick();
        jump_to(32'h100);
        fetch(mk(4'h6, 4'h3, 16'hFFFE, 4'h0, 4'h1), 1);
        comp_true = 1'b0;
        settle(); tick();
        settle(); lit("bcond_not_taken_pc", pc, 32'h104); tick();

        // LD with dmem_done after 4 MEM cycles (pc 0x104)
        fetch(mk(4'h9, 4'h0, 16'h0010, 4'h5, 4'h6), 1);
        settle(); tick();
        dmem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            lit("ld_wait_re_we_ret", {29'd0, mem_re, reg_we, retire}, 32'd4);
            tick();
        end
        dmem_done = 1'b1;
        settle(); lit("ld_done_re_we_ret", {29'd0, mem_re, reg_we, retire}, 32'd7); tick();
        dmem_done = 1'b0;
        settle(); lit("ld_pc", pc, 32'h108); lit("ld_single_retire", {31'd0, retire}, 32'd0); tick();

        // Reset in the middle of a store
        fetch(mk(4'h5, 4'h0, 16'h0004, 4'h0, 4'h2), 1);
        settle(); tick();
        settle(); lit("st_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0; dmem_done = 1'b1;
        tick();
        rst_n = 1'b1; dmem_done = 1'b0;
        settle();
        lit("st_abort_we_ret", {30'd0, mem_we, retire}, 32'd0);
        lit("st_abort_pc", pc, RST_PC);
        tick();

        // PC wrap
        jump_to(32'hFFFF_FFFC);
        fetch(mk(4'h0, 4'h2, 16'h0000, 4'h1, 4'h2), 1);
        settle(); tick();
        settle(); lit("wrap_pc", pc, 32'h0); tick();

        // Illegal opcode, halt, recovery
        jump_to(32'h40);
        fetch(mk(4'hF, 4'h0, 16'h0, 4'h0, 4'h0), 1);
        settle(); lit("illegal_no_retire", {31'd0, retire}, 32'd0); tick();
        imem_ack = 1'b1; dmem_done = 1'b1;
        settle(); lit("halt_flag_req", {30'd0, illegal, imem_req}, 32'd2); tick();
        settle(); lit("halt_pc", pc, 32'h40); lit("halt_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0; tick();
        rst_n = 1'b1; imem_ack = 1'b0; dmem_done = 1'b0;
        settle();
        lit("recover_flag_req", {30'd0, illegal, imem_req}, 32'd1);
        lit("recover_addr", imem_addr, RST_PC);
        tick();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int k;
            logic [3:0] cls;
            k   = int'($urandom_range(0, 40));
            cls = (k < 40) ? legal_cls[k % 8] : illegal_cls[$urandom_range(0, 7)];
            imem_ack   = ($urandom_range(0, 2) == 0);
            imem_rdata = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 16'hFFF), cls};
            comp_true  = $urandom_range(0, 1) == 1;
            alu_result = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0)
                       | 32'($urandom_range(0, 32'hFFFF));
            dmem_done  = ($urandom_range(0, 2) == 0);
            if (m_ph == 3) rst_n = ($urandom_range(0, 3) != 0);
            else           rst_n = ($urandom_range(0, 150) != 0);
            settle(); tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 32'd4: byte increment per sequential instruction.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 imem_req  out  1  instruction fetch request; imem_addr  out  32  fetch address (= pc).
REQ-006 imem_ack  in  1  fetch complete; imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-007 func  out  5  ALU function {cmp, iword[7:4]}; imm  out  32  sign-extended iword[23:8]; alu_src_imm  out  1  ALU operand 2 = imm.
REQ-008 rd, rs1, rs2  out  4 each  iword[31:28], [27:24], [23:20].
REQ-009 reg_we, mem_re, mem_we  out  1 each  register write, data read, data write strobes.
REQ-010 comp_true  in  1  ALU comparison result; alu_result  in  32  ALU dataOut (JAL target).
REQ-011 dmem_done  in  1  data access complete; link_pc  out  32  pc+PC_STEP for JAL write-back.
REQ-012 pc  out  32  current PC; retire  out  1  one-cycle pulse per completed instruction; illegal  out  1  sticky illegal-opcode flag.

Function
REQ-013 Class = iword[3:0]: 4'h0 ALUR, 4'h8 ALUI, 4'h2 CMPR, 4'hA CMPI, 4'h6 BCOND, 4'h9 LD, 4'h5 ST, 4'hB JAL; any other value is illegal.
REQ-014 func SHALL be {1'b0,iword[7:4]} for ALUR/ALUI, {1'b1,iword[7:4]} for CMPR/CMPI/BCOND, 5'b00000 for LD/ST/JAL.
REQ-015 alu_src_imm SHALL be 1 for ALUI, CMPI, LD, ST, JAL; 0 otherwise.
REQ-016 FSM states FETCH, EXEC, MEM, HALT; reset state FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc held stable; on imem_ack=1 latch imem_rdata into iword, go EXEC (ack in first request cycle allowed; minimum fetch latency 1 cycle).
REQ-018 EXEC (one cycle): decoded outputs valid from registered iword; illegal class -> set illegal, go HALT, no retire, pc unchanged.
REQ-019 EXEC, ALUR/ALUI/CMPR/CMPI: reg_we=1, retire=1, pc<=pc+PC_STEP, go FETCH.
REQ-020 EXEC, BCOND: reg_we=0; comp_true=1 -> pc<=pc+PC_STEP+(imm<<2), else pc<=pc+PC_STEP; retire=1, go FETCH.
REQ-021 EXEC, JAL: reg_we=1, link_pc=pc+PC_STEP, pc<=alu_result & ~32'h3, retire=1, go FETCH.
REQ-022 EXEC, LD/ST: go MEM; MEM holds decoded outputs, mem_re=1 (LD) or mem_we=1 (ST) every MEM cycle until dmem_done=1.
REQ-023 MEM with dmem_done=1: reg_we=1 for LD only in that cycle, retire=1, pc<=pc+PC_STEP, go FETCH.
REQ-024 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 without flag.
REQ-025 imem_ack outside FETCH and dmem_done outside MEM SHALL be ignored.
REQ-026 HALT is terminal until reset; all strobes 0, imem_req=0.
REQ-027 All strobes (imem_req, reg_we, mem_re, mem_we, retire) SHALL be 0 in states where not stated above.

Reset
REQ-028 rst_n=0 sampled on clk edge SHALL set state FETCH, pc=RESET_PC, iword=0, illegal=0; all strobes 0 the following cycle.
REQ-029 Reset during FETCH/MEM aborts the access; no retire, no register or memory write issued after the reset edge.

Structure
REQ-030 Shared package SHALL hold class opcode constants, FSM state enum, and the 5-bit func type shared with the ALU.
REQ-031 One sub-module fdu_decode (pure combinational iword -> func/imm/regs/controls/illegal) is natural; FSM and PC stay in top.

Verification
REQ-032 Reset, imem_ack after 3 cycles, ALUI fn=0 imm=5 -> imem_addr=0 held 3 cycles, func=5'b00000, alu_src_imm=1, reg_we=1, retire=1, pc=4.
REQ-033 BCOND at pc=0x100, imm=-2, comp_true=1 -> pc=0x0FC; same with comp_true=0 -> pc=0x104.
REQ-034 LD with dmem_done after 4 MEM cycles -> mem_re=1 for 4 cycles, reg_we only in done cycle, one retire.
REQ-035 JAL at pc=0x20, alu_result=0x203 -> link_pc=0x24, pc=0x200, reg_we=1.
REQ-036 iword[3:0]=4'hF -> illegal=1, HALT, imem_req=0 thereafter; rst_n=0 clears and refetches at RESET_PC.
REQ-037 pc=32'hFFFF_FFFC ALUR -> pc=0; rst_n=0 mid-MEM ST -> mem_we=0 next cycle, no retire.
